// File: rtl/uc_intc.sv
// Single-level interrupt controller beside the control unit: captures rising-edge
// requests, redirects the PC to a per-source vector at an instruction boundary, returns via EPC.
module uc_intc #(
  parameter int unsigned          NIRQ       = 4,
  parameter int unsigned          PC_W       = 10,
  parameter logic [PC_W-1:0]      VEC_BASE   = 'h3C0,
  parameter int unsigned          VEC_STRIDE = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_in,
  input  logic            ien_set,
  input  logic            ien_clr,
  input  logic            fetch_ok,
  input  logic            ret_int,
  input  logic [PC_W-1:0] pc_next,
  output logic            take,
  output logic [PC_W-1:0] vector,
  output logic            s_reti,
  output logic [PC_W-1:0] epc,
  output logic [NIRQ-1:0] ack,
  output logic [NIRQ-1:0] in_service,
  output logic [NIRQ-1:0] mask,
  output logic            ien,
  output logic            busy,
  output logic            spurious
);

  localparam int unsigned ID_W = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TAKE    = 2'd1,
    S_SERVICE = 2'd2,
    S_RETURN  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [NIRQ-1:0]   irq_q;
  logic [NIRQ-1:0]   pending_q, pending_d;
  logic [NIRQ-1:0]   mask_q, mask_d;
  logic              ien_q, ien_d;
  logic [PC_W-1:0]   epc_q, epc_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [NIRQ-1:0]   insv_q, insv_d;
  logic              spur_q, spur_d;

  logic [NIRQ-1:0]   irq_rise;
  logic [NIRQ-1:0]   eligible;
  logic [NIRQ-1:0]   ack_vec;
  logic              win_vld;
  logic [ID_W-1:0]   win_id;

  // Vector address wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] vec_addr(input logic [ID_W-1:0] idx);
    logic [PC_W-1:0] off;
    off = PC_W'(idx) * PC_W'(VEC_STRIDE);
    return VEC_BASE + off;
  endfunction

  assign irq_rise = irq & ~irq_q;
  assign eligible = pending_q & mask_q;
  assign ack_vec  = (state_q == S_TAKE) ? (NIRQ'(1) << id_q) : '0;

  // Lowest index wins: scan from the top so the last hit is the smallest index.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = (pending_q & ~ack_vec) | irq_rise;
    mask_d    = mask_we ? mask_in : mask_q;
    ien_d     = ien_q;
    epc_d     = epc_q;
    id_d      = id_q;
    insv_d    = insv_q;
    spur_d    = spur_q | (ret_int & ((state_q == S_IDLE) | (state_q == S_TAKE)));

    case (state_q)
      S_IDLE: begin
        if (ien_q && win_vld && fetch_ok) begin
          state_d = S_TAKE;
          id_d    = win_id;
          epc_d   = pc_next;
          ien_d   = 1'b0;
        end else if (ien_clr) begin
          ien_d = 1'b0;
        end else if (ien_set) begin
          ien_d = 1'b1;
        end
      end
      S_TAKE: begin
        insv_d  = ack_vec;
        state_d = S_SERVICE;
      end
      S_SERVICE: begin
        if (ret_int) state_d = S_RETURN;
      end
      S_RETURN: begin
        insv_d  = '0;
        ien_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      ien_q     <= 1'b0;
      epc_q     <= '0;
      id_q      <= '0;
      insv_q    <= '0;
      spur_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      ien_q     <= ien_d;
      epc_q     <= epc_d;
      id_q      <= id_d;
      insv_q    <= insv_d;
      spur_q    <= spur_d;
    end
  end

  assign take       = (state_q == S_TAKE);
  assign s_reti     = (state_q == S_RETURN);
  assign vector     = vec_addr(id_q);
  assign epc        = epc_q;
  assign ack        = ack_vec;
  assign in_service = insv_q;
  assign mask       = mask_q;
  assign ien        = ien_q;
  assign busy       = (state_q != S_IDLE);
  assign spurious   = spur_q;

  a_take_reti_excl: assert property (@(posedge clock) disable iff (!reset) !(take && s_reti));
  a_ack_onehot0:    assert property (@(posedge clock) disable iff (!reset) $onehot0(ack));
  a_insv_onehot0:   assert property (@(posedge clock) disable iff (!reset) $onehot0(in_service));

endmodule

// File: tb/tb_uc_intc.sv
// Directed, table-driven bench for uc_intc with hand-computed expected outputs.
module tb_uc_intc;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       ien_set;
  logic       ien_clr;
  logic       fetch_ok;
  logic       ret_int;
  logic [9:0] pc_next;
  logic       take;
  logic [9:0] vector;
  logic       s_reti;
  logic [9:0] epc;
  logic [3:0] ack;
  logic [3:0] in_service;
  logic [3:0] mask;
  logic       ien;
  logic       busy;
  logic       spurious;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  uc_intc dut (
    .clock(clock), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
    .ien_set(ien_set), .ien_clr(ien_clr), .fetch_ok(fetch_ok), .ret_int(ret_int),
    .pc_next(pc_next), .take(take), .vector(vector), .s_reti(s_reti), .epc(epc),
    .ack(ack), .in_service(in_service), .mask(mask), .ien(ien), .busy(busy),
    .spurious(spurious)
  );

  typedef struct {
    logic [3:0]  irq;
    logic        mwe;
    logic [3:0]  min;
    logic        iset;
    logic        iclr;
    logic        fok;
    logic        ret;
    logic [9:0]  pc;
    logic [36:0] exp;
  } vec_t;

  vec_t tbl[$];

  // exp = {take, vector, s_reti, epc, ack, in_service, mask, ien, busy, spurious}
  function automatic vec_t mk(input logic [3:0] i_irq, input logic i_mwe, input logic [3:0] i_min,
                              input logic i_iset, input logic i_iclr, input logic i_fok,
                              input logic i_ret, input logic [9:0] i_pc,
                              input logic e_take, input logic [9:0] e_vec, input logic e_sreti,
                              input logic [9:0] e_epc, input logic [3:0] e_ack,
                              input logic [3:0] e_insv, input logic [3:0] e_mask,
                              input logic e_ien, input logic e_busy, input logic e_spur);
    vec_t v;
    v.irq  = i_irq;  v.mwe = i_mwe; v.min = i_min; v.iset = i_iset;
    v.iclr = i_iclr; v.fok = i_fok; v.ret = i_ret; v.pc   = i_pc;
    v.exp  = {e_take, e_vec, e_sreti, e_epc, e_ack, e_insv, e_mask, e_ien, e_busy, e_spur};
    return v;
  endfunction

  function automatic logic [36:0] obs();
    return {take, vector, s_reti, epc, ack, in_service, mask, ien, busy, spurious};
  endfunction

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    irq = v.irq; mask_we = v.mwe; mask_in = v.min; ien_set = v.iset;
    ien_clr = v.iclr; fetch_ok = v.fok; ret_int = v.ret; pc_next = v.pc;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int takes;
    reset = 1'b0; irq = 4'hF; mask_we = 1'b0; mask_in = 4'h0; ien_set = 1'b0;
    ien_clr = 1'b0; fetch_ok = 1'b0; ret_int = 1'b0; pc_next = 10'h0;
    #3;
    check("reset_state", obs(), {1'b0, 10'h3C0, 1'b0, 10'h000, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0});

    // irq held high through reset: captured as pending, but mask/ien keep it quiet.
    @(negedge clock); reset = 1'b1;
    takes = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (take || busy) takes++;
    end
    check("quiet_20_cycles", 37'(takes), 37'd0);
    drive(mk(4'hF, 1, 4'hF, 1, 0, 0, 0, 10'h000,  0, 10'h3C0, 0, 10'h000, 4'h0, 4'h0, 4'hF, 1, 0, 0));
    check("pend_enable", obs(), tbl.size() == 0 ? {1'b0, 10'h3C0, 1'b0, 10'h000, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0} : 37'd0);
    drive(mk(4'hF, 0, 4'h0, 0, 0, 1, 0, 10'h0AA,  0, 10'h000, 0, 10'h000, 4'h0, 4'h0, 4'h0, 0, 0, 0));
    check("pend_take_src0", obs(), {1'b1, 10'h3C0, 1'b0, 10'h0AA, 4'h1, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0});

    reset = 1'b0; irq = 4'h0; fetch_ok = 1'b0;
    @(negedge clock); @(negedge clock); reset = 1'b1;

    //          irq  we min  set clr fok ret pc        take vec  sreti epc     ack   insv  mask ien busy spur
    tbl.push_back(mk(4'h0, 1, 4'hF, 1, 0, 0, 0, 10'h000,  0, 10'h3C0, 0, 10'h000, 4'h0, 4'h0, 4'hF, 1, 0, 0));
    tbl.push_back(mk(4'h4, 0, 4'h0, 0, 0, 0, 0, 10'h000,  0, 10'h3C0, 0, 10'h000, 4'h0, 4'h0, 4'hF, 1, 0, 0));
    tbl.push_back(mk(4'h4, 0, 4'h0, 0, 0, 1, 0, 10'h025,  1, 10'h3C8, 0, 10'h025, 4'h4, 4'h0, 4'hF, 0, 1, 0));
    tbl.push_back(mk(4'h4, 0, 4'h0, 0, 0, 0, 0, 10'h000,  0, 10'h3C8, 0, 10'h025, 4'h0, 4'h4, 4'hF, 0, 1, 0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 1, 10'h000,  0, 10'h3C8, 1, 10'h025, 4'h0, 4'h4, 4'hF, 0, 1, 0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 0, 10'h000,  0, 10'h3C8, 0, 10'h025, 4'h0, 4'h0, 4'hF, 1, 0, 0));
    tbl.push_back(mk(4'hA, 0, 4'h0, 0, 0, 0, 0, 10'h000,  0, 10'h3C8, 0, 10'h025, 4'h0, 4'h0, 4'hF, 1, 0, 0));
    tbl.push_back(mk(4'hA, 0, 4'h0, 0, 0, 1, 0, 10'h100,  1, 10'h3C4, 0, 10'h100, 4'h2, 4'h0, 4'hF, 0, 1, 0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 0, 10'h000,  0, 10'h3C4, 0, 10'h100, 4'h0, 4'h2, 4'hF, 0, 1, 0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 1, 10'h000,  0, 10'h3C4, 1, 10'h100, 4'h0, 4'h2, 4'hF, 0, 1, 0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 1, 0, 10'h200,  0, 10'h3C4, 0, 10'h100, 4'h0, 4'h0, 4'hF, 1, 0, 0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 1, 0, 10'h201,  1, 10'h3CC, 0, 10'h201, 4'h8, 4'h0, 4'hF, 0, 1, 0));
    tbl.push_back(mk(4'h1, 0, 4'h0, 0, 0, 0, 0, 10'h000,  0, 10'h3CC, 0, 10'h201, 4'h0, 4'h8, 4'hF, 0, 1, 0));
    tbl.push_back(mk(4'h1, 0, 4'h0, 0, 0, 1, 0, 10'h300,  0, 10'h3CC, 0, 10'h201, 4'h0, 4'h8, 4'hF, 0, 1, 0));
    tbl.push_back(mk(4'h1, 0, 4'h0, 1, 0, 0, 0, 10'h000,  0, 10'h3CC, 0, 10'h201, 4'h0, 4'h8, 4'hF, 0, 1, 0));
    tbl.push_back(mk(4'h1, 0, 4'h0, 0, 0, 0, 1, 10'h000,  0, 10'h3CC, 1, 10'h201, 4'h0, 4'h8, 4'hF, 0, 1, 0));
    tbl.push_back(mk(4'h1, 0, 4'h0, 0, 0, 0, 0, 10'h000,  0, 10'h3CC, 0, 10'h201, 4'h0, 4'h0, 4'hF, 1, 0, 0));
    tbl.push_back(mk(4'h1, 0, 4'h0, 0, 0, 1, 0, 10'h304,  1, 10'h3C0, 0, 10'h304, 4'h1, 4'h0, 4'hF, 0, 1, 0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 0, 10'h000,  0, 10'h3C0, 0, 10'h304, 4'h0, 4'h1, 4'hF, 0, 1, 0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 1, 10'h000,  0, 10'h3C0, 1, 10'h304, 4'h0, 4'h1, 4'hF, 0, 1, 0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 0, 10'h000,  0, 10'h3C0, 0, 10'h304, 4'h0, 4'h0, 4'hF, 1, 0, 0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 1, 10'h000,  0, 10'h3C0, 0, 10'h304, 4'h0, 4'h0, 4'hF, 1, 0, 1));
    tbl.push_back(mk(4'h0, 0, 4'h0, 1, 1, 0, 0, 10'h000,  0, 10'h3C0, 0, 10'h304, 4'h0, 4'h0, 4'hF, 0, 0, 1));
    tbl.push_back(mk(4'h4, 0, 4'h0, 0, 0, 1, 0, 10'h305,  0, 10'h3C0, 0, 10'h304, 4'h0, 4'h0, 4'hF, 0, 0, 1));
    tbl.push_back(mk(4'h4, 1, 4'hB, 1, 0, 0, 0, 10'h000,  0, 10'h3C0, 0, 10'h304, 4'h0, 4'h0, 4'hB, 1, 0, 1));
    tbl.push_back(mk(4'h4, 0, 4'h0, 0, 0, 1, 0, 10'h306,  0, 10'h3C0, 0, 10'h304, 4'h0, 4'h0, 4'hB, 1, 0, 1));
    tbl.push_back(mk(4'h4, 1, 4'hF, 0, 0, 1, 0, 10'h307,  0, 10'h3C0, 0, 10'h304, 4'h0, 4'h0, 4'hF, 1, 0, 1));
    tbl.push_back(mk(4'h4, 0, 4'h0, 0, 0, 1, 0, 10'h3FF,  1, 10'h3C8, 0, 10'h3FF, 4'h4, 4'h0, 4'hF, 0, 1, 1));
    tbl.push_back(mk(4'h4, 0, 4'h0, 0, 0, 0, 0, 10'h000,  0, 10'h3C8, 0, 10'h3FF, 4'h0, 4'h4, 4'hF, 0, 1, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      check($sformatf("row%0d", i), obs(), tbl[i].exp);
    end

    // Asynchronous reset while in SERVICE: outputs clear between clock edges.
    #2;
    reset = 1'b0; irq = 4'h0; fetch_ok = 1'b0;
    #1;
    check("async_reset_mid_service", obs(), {1'b0, 10'h3C0, 1'b0, 10'h000, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0});
    @(negedge clock); reset = 1'b1;
    drive(mk(4'h0, 1, 4'hF, 1, 0, 0, 0, 10'h000,  0, 10'h000, 0, 10'h000, 4'h0, 4'h0, 4'h0, 0, 0, 0));
    check("post_reset_enable", obs(), {1'b0, 10'h3C0, 1'b0, 10'h000, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0});
    drive(mk(4'h0, 0, 4'h0, 0, 0, 1, 0, 10'h123,  0, 10'h000, 0, 10'h000, 4'h0, 4'h0, 4'h0, 0, 0, 0));
    check("post_reset_no_pending", obs(), {1'b0, 10'h3C0, 1'b0, 10'h000, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
